// File: rtl/adc366x_dly_cal.sv
// ---------------------------------------------------------------------------
// adc366x_dly_cal
//   Delay-calibration sequencer for the ADC366x LVDS receiver. Sweeps one
//   common IDELAY tap (0..31) across all lanes while the ADC sends a test
//   pattern, tracks the longest contiguous error-free run per lane and
//   finally loads the centre of that run (or DEF_TAP for a failing lane).
//
// Ports
//   cfg_clk_i    configuration clock
//   cfg_rst_i    synchronous active-high reset
//   cal_start_i  start request, honoured only in IDLE
//   mon_ok_i     per-lane pattern-match level (cfg_clk_i domain)
//   cfg_dly_o    [5n+:5] lane n tap, [5*SW] load strobe (rising edge loads)
//   cal_busy_o   high whenever the sequencer is not IDLE
//   cal_done_o   sticky completion flag, cleared by the next accepted start
//   cal_err_o    per-lane failure (best run shorter than MIN_EYE)
//   eye_len_o    per-lane best run length, [6n+:6] (only with the macro)
//
// Configuration macro: ADC366X_CAL_STATS_EN adds the eye_len_o output.
// ---------------------------------------------------------------------------
module adc366x_dly_cal #(
  parameter int SW         = 5,
  parameter int SETTLE_CYC = 64,
  parameter int WIN_CYC    = 1024,
  parameter int MIN_EYE    = 4,
  parameter int DEF_TAP    = 16,
  parameter int LD_HI      = 4
) (
  input  logic            cfg_clk_i,
  input  logic            cfg_rst_i,
  input  logic            cal_start_i,
  input  logic [SW-1:0]   mon_ok_i,
  output logic [5*SW:0]   cfg_dly_o,
  output logic            cal_busy_o,
  output logic            cal_done_o,
  output logic [SW-1:0]   cal_err_o
`ifdef ADC366X_CAL_STATS_EN
  ,
  output logic [6*SW-1:0] eye_len_o
`endif
);

  localparam int CW = $clog2(WIN_CYC + SETTLE_CYC + LD_HI + 1) + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, SAMPLE, EVAL, CENTER, APPLY
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      tap_q, tap_d;
  logic [5*SW-1:0] fld_q, fld_d;
  logic            done_q, done_d;
  logic [SW-1:0]   err_q, err_d;
  logic [SW-1:0]   bad_q, bad_d;
  logic [5:0]      run_len_q [SW];
  logic [5:0]      run_len_d [SW];
  logic [4:0]      run_start_q [SW];
  logic [4:0]      run_start_d [SW];
  logic [5:0]      best_len_q [SW];
  logic [5:0]      best_len_d [SW];
  logic [4:0]      best_start_q [SW];
  logic [4:0]      best_start_d [SW];
  logic [5:0]      new_len;
`ifdef ADC366X_CAL_STATS_EN
  logic [6*SW-1:0] eye_q, eye_d;
`endif

  always_ff @(posedge cfg_clk_i) begin
    if (cfg_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tap_q   <= '0;
      fld_q   <= {SW{5'(DEF_TAP)}};
      done_q  <= 1'b0;
      err_q   <= '0;
      bad_q   <= '0;
      for (int n = 0; n < SW; n++) begin
        run_len_q[n]    <= '0;
        run_start_q[n]  <= '0;
        best_len_q[n]   <= '0;
        best_start_q[n] <= '0;
      end
`ifdef ADC366X_CAL_STATS_EN
      eye_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      fld_q        <= fld_d;
      done_q       <= done_d;
      err_q        <= err_d;
      bad_q        <= bad_d;
      run_len_q    <= run_len_d;
      run_start_q  <= run_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
`ifdef ADC366X_CAL_STATS_EN
      eye_q <= eye_d;
`endif
    end
  end

  // Lane fields are registered and change only in IDLE, EVAL and CENTER, so
  // they are already stable when the strobe rises in LOAD/APPLY.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tap_d        = tap_q;
    fld_d        = fld_q;
    done_d       = done_q;
    err_d        = err_q;
    bad_d        = bad_q;
    run_len_d    = run_len_q;
    run_start_d  = run_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    new_len      = '0;
`ifdef ADC366X_CAL_STATS_EN
    eye_d = eye_q;
`endif
    case (state_q)
      IDLE: begin
        if (cal_start_i) begin
          done_d = 1'b0;
          err_d  = '0;
          bad_d  = '0;
          tap_d  = '0;
          cnt_d  = '0;
          fld_d  = '0;
          for (int n = 0; n < SW; n++) begin
            run_len_d[n]    = '0;
            run_start_d[n]  = '0;
            best_len_d[n]   = '0;
            best_start_d[n] = '0;
          end
`ifdef ADC366X_CAL_STATS_EN
          eye_d = '0;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == CW'(LD_HI - 1)) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          bad_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        bad_d = bad_q | ~mon_ok_i;
        if (cnt_q == CW'(WIN_CYC - 1)) begin
          cnt_d   = '0;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EVAL: begin
        // Strictly-greater update keeps the earliest of equal-length runs.
        for (int n = 0; n < SW; n++) begin
          if (!bad_q[n]) begin
            new_len      = run_len_q[n] + 6'd1;
            run_len_d[n] = new_len;
            if (run_len_q[n] == 6'd0) run_start_d[n] = tap_q;
            if (new_len > best_len_q[n]) begin
              best_len_d[n]   = new_len;
              best_start_d[n] = (run_len_q[n] == 6'd0) ? tap_q : run_start_q[n];
            end
          end else begin
            run_len_d[n] = '0;
          end
        end
        if (tap_q == 5'd31) begin
          state_d = CENTER;
        end else begin
          tap_d   = tap_q + 5'd1;
          fld_d   = {SW{tap_q + 5'd1}};
          state_d = LOAD;
        end
      end
      CENTER: begin
        for (int n = 0; n < SW; n++) begin
          if (best_len_q[n] >= 6'(MIN_EYE)) begin
            fld_d[5*n +: 5] = best_start_q[n] + 5'((best_len_q[n] - 6'd1) >> 1);
          end else begin
            fld_d[5*n +: 5] = 5'(DEF_TAP);
            err_d[n]        = 1'b1;
          end
`ifdef ADC366X_CAL_STATS_EN
          eye_d[6*n +: 6] = best_len_q[n];
`endif
        end
        cnt_d   = '0;
        state_d = APPLY;
      end
      APPLY: begin
        // LD_HI strobe cycles, then one strobe-low cycle before done.
        if (cnt_q == CW'(LD_HI)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_dly_o  = {(state_q == LOAD) || ((state_q == APPLY) && (cnt_q < CW'(LD_HI))), fld_q};
  assign cal_busy_o = (state_q != IDLE);
  assign cal_done_o = done_q;
  assign cal_err_o  = err_q;
`ifdef ADC366X_CAL_STATS_EN
  assign eye_len_o  = eye_q;
`endif

endmodule

// File: tb/tb_adc366x_dly_cal.sv
// ---------------------------------------------------------------------------
// tb_adc366x_dly_cal
//   Directed bench for adc366x_dly_cal. Shortened settle/window parameters
//   keep each calibration near 1.5k cycles; latency is checked against the
//   closed-form count for those parameters. A behavioural ADC drives
//   mon_ok_i from per-lane good-tap masks indexed by each lane's current tap.
// ---------------------------------------------------------------------------
module tb_adc366x_dly_cal;

  localparam int SW     = 5;
  localparam int SETTLE = 8;
  localparam int WIN    = 32;
  localparam int LDHI   = 4;
  localparam int PER    = LDHI + SETTLE + WIN + 1;
  localparam int LAT    = 32 * PER + LDHI + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] monOk;
  logic [5*SW:0] dly;
  logic          busy, done;
  logic [SW-1:0] err;
`ifdef ADC366X_CAL_STATS_EN
  logic [6*SW-1:0] eyeLen;
`endif

  logic [31:0] goodMask [SW];
  logic        drop = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          rises = 0;
  int          widthBad = 0;
  int          hiWidth = 0;
  logic        prevStb = 1'b0;
  int          latency;

  always #5 clk = ~clk;

  adc366x_dly_cal #(
    .SW(SW), .SETTLE_CYC(SETTLE), .WIN_CYC(WIN), .MIN_EYE(4), .DEF_TAP(16), .LD_HI(LDHI)
  ) dut (
    .cfg_clk_i   (clk),
    .cfg_rst_i   (rst),
    .cal_start_i (start),
    .mon_ok_i    (monOk),
    .cfg_dly_o   (dly),
    .cal_busy_o  (busy),
    .cal_done_o  (done),
    .cal_err_o   (err)
`ifdef ADC366X_CAL_STATS_EN
    ,
    .eye_len_o   (eyeLen)
`endif
  );

  // Behavioural ADC: each lane reports ok when its current tap is in its mask.
  always_comb begin
    for (int n = 0; n < SW; n++) begin
      monOk[n] = goodMask[n][dly[5*n +: 5]];
    end
    if (drop) monOk[0] = 1'b0;
  end

  // Strobe monitor: counts rising edges and flags pulses not LDHI wide.
  always @(negedge clk) begin
    if (dly[5*SW] && !prevStb) begin
      rises   = rises + 1;
      hiWidth = 1;
    end else if (dly[5*SW]) begin
      hiWidth = hiWidth + 1;
    end else if (prevStb && hiWidth != LDHI) begin
      widthBad = widthBad + 1;
    end
    prevStb = dly[5*SW];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses start for one edge, then counts edges until done is seen.
  // Drop points name the edge count after which lane 0 is forced bad.
  task automatic applyStimulus(input int dropA, input int dropB, input int midStart);
    int n;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    latency = -1;
    while (n < LAT + 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      drop  = (n == dropA) || (n == dropB);
      start = (n == midStart);
      if (done) begin
        latency = n;
        break;
      end
    end
    drop  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int risesBefore;
    int widthBefore;
    goodMask[0] = 32'hFFFF_FFFF;
    goodMask[1] = 32'hFFFF_FFFF;
    goodMask[2] = 32'hFFFF_FFFF;
    goodMask[3] = 32'hFFFF_FFFF;
    goodMask[4] = 32'hFFFF_FFFF;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_dly",  32'(dly), 32'h0108_4210);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err",  32'(err), 32'd0);

    // Run A: mixed lanes, plus a start pulse mid-run that must be ignored.
    $display("[TB] run A: mixed eyes");
    goodMask[0] = 32'h000F_FF00;
    goodMask[1] = 32'hF000_0000;
    goodMask[2] = 32'h0000_3C3C;
    goodMask[3] = 32'hFFFF_FFFF;
    goodMask[4] = 32'h0000_0000;
    risesBefore = rises;
    widthBefore = widthBad;
    applyStimulus(-1, -1, 300);
    checkOutput("A_latency", 32'(latency), 32'(LAT));
    checkOutput("A_tap0", 32'(dly[4:0]),   32'd13);
    checkOutput("A_tap1", 32'(dly[9:5]),   32'd29);
    checkOutput("A_tap2", 32'(dly[14:10]), 32'd3);
    checkOutput("A_tap3", 32'(dly[19:15]), 32'd15);
    checkOutput("A_tap4", 32'(dly[24:20]), 32'd16);
    checkOutput("A_err",  32'(err), 32'b10000);
    checkOutput("A_busy", 32'(busy), 32'd0);
    checkOutput("A_strobe_rises", 32'(rises - risesBefore), 32'd33);
    checkOutput("A_strobe_width", 32'(widthBad - widthBefore), 32'd0);
    checkOutput("A_strobe_low", 32'(dly[5*SW]), 32'd0);
`ifdef ADC366X_CAL_STATS_EN
    checkOutput("A_eye0", 32'(eyeLen[5:0]),   32'd12);
    checkOutput("A_eye1", 32'(eyeLen[11:6]),  32'd4);
    checkOutput("A_eye2", 32'(eyeLen[17:12]), 32'd4);
    checkOutput("A_eye3", 32'(eyeLen[23:18]), 32'd32);
    checkOutput("A_eye4", 32'(eyeLen[29:24]), 32'd0);
`endif

    // Run B: all lanes good; lane 0 loses one SAMPLE cycle at tap 10 and one
    // SETTLE cycle at tap 20 (the latter must not count).
    $display("[TB] run B: single-cycle drop");
    goodMask[0] = 32'hFFFF_FFFF;
    goodMask[1] = 32'hFFFF_FFFF;
    goodMask[2] = 32'hFFFF_FFFF;
    goodMask[4] = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("B_done_cleared", 32'(done), 32'd0);
    checkOutput("B_err_cleared",  32'(err), 32'd0);
    repeat (LAT + 20) @(posedge clk);
    @(negedge clk);
    checkOutput("B_done_idle", 32'(done), 32'd1);
    applyStimulus(10 * PER + LDHI + SETTLE + 7, 20 * PER + LDHI + 2, -1);
    checkOutput("B_latency", 32'(latency), 32'(LAT));
    checkOutput("B_tap0", 32'(dly[4:0]), 32'd21);
    checkOutput("B_taps_rest", 32'(dly[24:5]), 32'h7_BDEF);
    checkOutput("B_err", 32'(err), 32'd0);
`ifdef ADC366X_CAL_STATS_EN
    checkOutput("B_eye0", 32'(eyeLen[5:0]), 32'd21);
`endif

    // Run C: reset mid-sweep returns to reset values without applying.
    $display("[TB] run C: reset mid-sweep");
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(posedge clk);
    @(negedge clk);
    checkOutput("C_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("C_dly",  32'(dly), 32'h0108_4210);
    checkOutput("C_busy", 32'(busy), 32'd0);
    checkOutput("C_done", 32'(done), 32'd0);
    checkOutput("C_err",  32'(err), 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("C_stays_idle", 32'({busy, dly}), 32'h0108_4210);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
